countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Count-down companion to the stopwatch. Loads a preset in minutes and seconds, then decrements it once per second until it reaches 00:00.
- On reaching zero it raises a one-cycle `expired` pulse and a sticky `alarm` level.
- Runs entirely on the system clock. A one-second clock-enable is generated internally; no derived clock is used.
- Sits alongside the stopwatch under the clock top level and shares its status encoding.

Parameters:
- INPUT_FREQ, 100, number of clk cycles per one-second tick (must be ≥2).
- MAX_MIN, 99, largest loadable minutes value (must be ≤255).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  sample load_min/load_sec into the counters (level, sampled each cycle)
- load_min  input  8  preset minutes
- load_sec  input  6  preset seconds
- start  input  1  begin or resume counting down
- stop  input  1  pause counting
- clear  input  1  synchronous return to idle with zeroed count
- minutes  output  8  current minutes remaining
- seconds  output  6  current seconds remaining, range 0..59
- status  output  2  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
- expired  output  1  one-cycle pulse when the count reaches 00:00
- alarm  output  1  high from expiry until the next clear or load

Behaviour:
- Reset (asynchronous, rst=1):
  - minutes=0, seconds=0, status=IDLE, expired=0, alarm=0, prescaler=0.
  - Outputs hold these values while rst is high.
  - Operation resumes on the first clk edge after rst falls.
- Prescaler:
  - Counts 0..INPUT_FREQ-1 only in RUN.
  - tick=1 in the cycle where prescaler==INPUT_FREQ-1; the prescaler wraps to 0 on that cycle.
  - The prescaler is forced to 0 in any non-RUN state. The first decrement therefore occurs exactly INPUT_FREQ cycles after the cycle in which RUN is entered.
- Command priority, evaluated per cycle: clear > load > stop > start. Only the highest-priority asserted command acts.
- clear, in any state: next cycle minutes=0, seconds=0, status=IDLE, alarm=0, prescaler=0.
- load:
  - Accepted in IDLE, PAUSED and DONE; ignored in RUN.
  - Sets minutes=min(load_min,MAX_MIN) and seconds=min(load_sec,59).
  - Clears alarm and moves to IDLE.
- start:
  - IDLE or PAUSED with a nonzero count → RUN.
  - With count 00:00, start is ignored and the state does not change.
  - Ignored in RUN and DONE.
- stop: RUN → PAUSED. Count and prescaler freeze, with the prescaler zeroed. Ignored in other states.
- Decrement on tick in RUN:
  - If seconds>0: seconds-1.
  - Else if minutes>0: minutes-1 and seconds=59.
  - If the result is 00:00: status=DONE in the same cycle the result is registered, expired=1 for exactly that cycle, and alarm=1.
- Simultaneous events:
  - stop and tick in the same cycle: stop wins, no decrement.
  - clear in the expiry cycle: clear wins, expired=0, alarm=0.
- DONE:
  - Count holds at 00:00 and alarm stays high.
  - Exit only via clear or load.
- No wrap below zero and no arithmetic underflow. minutes never exceeds MAX_MIN.
- Registered outputs; no combinational path from inputs to outputs.

Decomposition:
- Shared clock package holds:
  - status encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSED=2'b10, ST_DONE=2'b11, common with the stopwatch control FSM;
  - the constant SEC_MAX=59.
- One natural sub-module, tick_gen: a parameterised INPUT_FREQ clock-enable generator with a synchronous zero/hold input. It is reusable by the stopwatch in place of a derived clock.
- FSM and down-counter stay in countdown_timer.

Test Plan (INPUT_FREQ=4):
- rst pulse mid-RUN → all outputs 0 and status=00 immediately (asynchronously), before the next clk edge.
- load 01:02, start → status=01. Values seen at cycles 4/8/12: 01:01, 01:00, 00:59. 00:00 is reached at cycle 248 after the start cycle, with expired high exactly 1 cycle and alarm staying high, status=11.
- load_min=200, load_sec=63 → minutes=99, seconds=59. Then start with a 00:00 preset (after clear) → status stays 00.
- load 00:05, start, stop asserted at cycle 6 → count 00:04, status=10, no change over 20 cycles. Start again → next decrement 4 cycles later to 00:03.
- load and start asserted together in IDLE → load acts, status stays 00. load asserted in RUN → ignored, count continues.
- load 00:01, start, clear asserted in the expiry cycle → minutes=0, seconds=0, status=00, expired never seen, alarm=0.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared clock-block definitions: status encoding used by the stopwatch and the
// countdown timer, plus the minutes:seconds count type and its decrement helper.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } status_t;

    localparam int unsigned SEC_MAX = 59;

    typedef struct packed {
        logic [7:0] minutes;
        logic [5:0] seconds;
    } mmss_t;

    // Borrow from minutes when seconds are exhausted; saturates at 00:00.
    function automatic mmss_t mmss_dec(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.seconds != 6'd0) begin
            r.seconds = t.seconds - 6'd1;
        end else if (t.minutes != 8'd0) begin
            r.minutes = t.minutes - 8'd1;
            r.seconds = 6'(SEC_MAX);
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// One-cycle clock-enable every INPUT_FREQ cycles; a synchronous zero input
// holds the prescaler at 0 so the next tick lands a full period later.
module tick_gen #(
    parameter int INPUT_FREQ = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic zero,
    output logic tick
);

    localparam int W = (INPUT_FREQ > 2) ? $clog2(INPUT_FREQ) : 1;
    localparam logic [W-1:0] LAST = W'(INPUT_FREQ - 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (zero || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with start/stop/clear/load control, a
// one-cycle expiry pulse and a sticky alarm level.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int INPUT_FREQ = 100,
    parameter int MAX_MIN    = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [7:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] status,
    output logic       expired,
    output logic       alarm
);

    localparam logic [7:0] MAX_MIN_L = 8'(MAX_MIN);
    localparam logic [5:0] SEC_MAX_L = 6'(SEC_MAX);

    status_t state_reg, state_next;
    mmss_t   cnt_reg, cnt_next;
    mmss_t   cnt_dec, cnt_load;
    logic    alarm_reg, alarm_next;
    logic    expired_reg, expired_next;
    logic    do_dec;
    logic    tick;
    logic    presc_zero;

    // Zero the prescaler whenever we are not running or about to leave RUN,
    // so every entry into RUN waits a full INPUT_FREQ period.
    assign presc_zero = (state_reg != ST_RUN) || (state_next != ST_RUN);

    tick_gen #(
        .INPUT_FREQ(INPUT_FREQ)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .zero(presc_zero),
        .tick(tick)
    );

    assign cnt_dec          = mmss_dec(cnt_reg);
    assign cnt_load.minutes = (load_min > MAX_MIN_L) ? MAX_MIN_L : load_min;
    assign cnt_load.seconds = (load_sec > SEC_MAX_L) ? SEC_MAX_L : load_sec;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        alarm_next   = alarm_reg;
        expired_next = 1'b0;
        do_dec       = 1'b0;

        if (clear) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            alarm_next = 1'b0;
        end else if (load) begin
            // A load during RUN is ignored but still masks stop/start.
            if (state_reg != ST_RUN) begin
                state_next = ST_IDLE;
                cnt_next   = cnt_load;
                alarm_next = 1'b0;
            end else begin
                do_dec = tick;
            end
        end else if (stop) begin
            if (state_reg == ST_RUN) begin
                state_next = ST_PAUSED;
            end
        end else if (state_reg == ST_RUN) begin
            do_dec = tick;
        end else if (start && (state_reg == ST_IDLE || state_reg == ST_PAUSED)
                     && cnt_reg != '0) begin
            state_next = ST_RUN;
        end

        if (do_dec) begin
            cnt_next = cnt_dec;
            if (cnt_dec == '0) begin
                state_next   = ST_DONE;
                expired_next = 1'b1;
                alarm_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            alarm_reg   <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            alarm_reg   <= alarm_next;
            expired_reg <= expired_next;
        end
    end

    assign minutes = cnt_reg.minutes;
    assign seconds = cnt_reg.seconds;
    assign status  = state_reg;
    assign expired = expired_reg;
    assign alarm   = alarm_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with INPUT_FREQ=4; expected values are
// hand-computed from the cycle-level behaviour of the timer.
module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic       expired;
    logic       alarm;

    int total = 0;
    int bad   = 0;

    countdown_timer #(
        .INPUT_FREQ(4),
        .MAX_MIN   (99)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_min(load_min),
        .load_sec(load_sec),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .minutes (minutes),
        .seconds (seconds),
        .status  (status),
        .expired (expired),
        .alarm   (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] m, input logic [5:0] s);
        load_min = m;
        load_sec = s;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_min = '0; load_sec = '0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        step(2);
        check("reset outputs", {16'd0, minutes, seconds, status, expired, alarm}, 32'd0);
        rst = 1'b0;
        step(1);
        check("post-reset status", status, 2'b00);

        // 01:02 runs to expiry after 62 ticks of 4 cycles = 248 cycles
        do_load(8'd1, 6'd2);
        check("load 01:02", {minutes, seconds}, {8'd1, 6'd2});
        pulse_start();
        check("run status", status, 2'b01);
        step(4);
        check("cyc4 01:01", {minutes, seconds}, {8'd1, 6'd1});
        step(4);
        check("cyc8 01:00", {minutes, seconds}, {8'd1, 6'd0});
        step(4);
        check("cyc12 00:59", {minutes, seconds}, {8'd0, 6'd59});
        step(235);
        check("cyc247 count", {minutes, seconds}, {8'd0, 6'd1});
        check("cyc247 expired", expired, 1'b0);
        check("cyc247 status", status, 2'b01);
        step(1);
        check("cyc248 count", {minutes, seconds}, 14'd0);
        check("cyc248 expired", expired, 1'b1);
        check("cyc248 alarm", alarm, 1'b1);
        check("cyc248 status", status, 2'b11);
        step(1);
        check("cyc249 expired", expired, 1'b0);
        check("cyc249 alarm", alarm, 1'b1);
        pulse_start();
        step(4);
        check("done holds status", status, 2'b11);
        check("done holds count", {minutes, seconds}, 14'd0);
        check("done holds alarm", alarm, 1'b1);

        // asynchronous reset in the middle of RUN
        do_load(8'd0, 6'd10);
        check("load clears alarm", alarm, 1'b0);
        pulse_start();
        step(6);
        rst = 1'b1;
        #1;
        check("async reset", {16'd0, minutes, seconds, status, expired, alarm}, 32'd0);
        #1;
        rst = 1'b0;
        step(1);
        check("after reset status", status, 2'b00);

        // saturating load, then start with 00:00 is ignored
        do_load(8'd200, 6'd63);
        check("load saturate", {minutes, seconds}, {8'd99, 6'd59});
        pulse_clear();
        check("clear count", {minutes, seconds}, 14'd0);
        pulse_start();
        check("start at zero", status, 2'b00);

        // pause and resume
        do_load(8'd0, 6'd5);
        pulse_start();
        step(4);
        check("pause pre 00:04", {minutes, seconds}, {8'd0, 6'd4});
        step(1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("paused status", status, 2'b10);
        check("paused count", {minutes, seconds}, {8'd0, 6'd4});
        step(20);
        check("paused hold status", status, 2'b10);
        check("paused hold count", {minutes, seconds}, {8'd0, 6'd4});
        pulse_start();
        check("resume status", status, 2'b01);
        step(3);
        check("resume cyc3", {minutes, seconds}, {8'd0, 6'd4});
        step(1);
        check("resume cyc4 00:03", {minutes, seconds}, {8'd0, 6'd3});
        pulse_clear();

        // load beats start; load ignored in RUN
        load_min = 8'd0; load_sec = 6'd5; load = 1'b1; start = 1'b1;
        step(1);
        load = 1'b0; start = 1'b0;
        check("load+start status", status, 2'b00);
        check("load+start count", {minutes, seconds}, {8'd0, 6'd5});
        pulse_start();
        load_sec = 6'd9; load = 1'b1;
        step(4);
        load = 1'b0;
        check("load in run status", status, 2'b01);
        check("load in run count", {minutes, seconds}, {8'd0, 6'd4});
        pulse_clear();

        // clear in the expiry cycle wins
        do_load(8'd0, 6'd1);
        pulse_start();
        step(3);
        check("pre-expiry count", {minutes, seconds}, {8'd0, 6'd1});
        pulse_clear();
        check("clear@expiry count", {minutes, seconds}, 14'd0);
        check("clear@expiry status", status, 2'b00);
        check("clear@expiry expired", expired, 1'b0);
        check("clear@expiry alarm", alarm, 1'b0);
        step(1);
        check("clear@expiry later exp", expired, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
